// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// The stage payload is sized for the widest supported datapath (64 bits,
// 6-bit amount); narrower instances use only the low WIDTH / LOG2W bits
// and keep the rest at zero.
package shift_pkg;

   localparam int SH_MAX_W = 64;
   localparam int SH_AMT_W = 6;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_type_t;

   // Partial result travelling down the pipe together with the amount
   // still to be applied and the flags that override the final value.
   typedef struct packed {
      logic [SH_MAX_W-1:0] data;
      logic [SH_AMT_W-1:0] amt;
      shift_type_t         typ;
      logic                force_zero;
      logic                force_sign;
      logic                carry;
   } shift_pay_t;

   // Stage that owns shift layer j (shift by 2^j).
   function automatic int layer_stage(input int j, input int stages, input int log2w);
      return (j * stages) / log2w;
   endfunction

endpackage

// File: rtl/shift_layer_stage.sv
// One register stage of the shifter: applies its share of the log-shifter layers, then registers.
// Latency: 1 cycle.
// Backpressure: loads only when load (downstream ready or stage empty) is high; holds otherwise.
//
// Ports: clk, reset_n (async, active-low), flush (clears valid), load (this stage may
// capture), in_valid/in_pay (previous stage or decode), out_valid/out_pay (registered).
module shift_layer_stage
   import shift_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int STAGES    = 2,
   parameter int STAGE_IDX = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       flush,
   input  logic       load,
   input  logic       in_valid,
   input  shift_pay_t in_pay,
   output logic       out_valid,
   output shift_pay_t out_pay
);

   localparam int LOG2W   = $clog2(WIDTH);
   localparam bit IS_LAST = (STAGE_IDX == STAGES - 1);

   shift_pay_t       nxt;
   logic [WIDTH-1:0] d;

   always_comb begin
      nxt = in_pay;
      d   = in_pay.data[WIDTH-1:0];
      for (int j = 0; j < LOG2W; j++) begin
         if (layer_stage(j, STAGES, LOG2W) == STAGE_IDX && in_pay.amt[j]) begin
            case (in_pay.typ)
               SH_LSL:  d = d << (1 << j);
               SH_LSR:  d = d >> (1 << j);
               SH_ASR:  d = WIDTH'($signed(d) >>> (1 << j));
               default: d = (d >> (1 << j)) | (d << (WIDTH - (1 << j)));
            endcase
         end
      end
      // Out-of-range amounts were decoded to amount 0 plus a flag; the
      // overriding value is applied once, just before the output register.
      if (IS_LAST) begin
         if (in_pay.force_zero) begin
            d = '0;
         end else if (in_pay.force_sign) begin
            d = {WIDTH{d[WIDTH-1]}};
         end
      end
      nxt.data[WIDTH-1:0] = d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_pay   <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (load) begin
            out_valid <= in_valid;
         end
         // Payload only moves with a real op so an idle output stays put.
         if (load && in_valid && !flush) begin
            out_pay <= nxt;
         end
      end
   end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined ARM shifter-operand unit (LSL/LSR/ASR/ROR/RRX with carry-out), WIDTH bits.
// Latency: STAGES cycles from acceptance when not stalled; 1 op/cycle throughput.
// Backpressure: valid/ready chain, bubbles collapse; output holds while out_valid && !out_ready.
//
// Ports: clk, reset_n (async, active-low), flush (sync kill of all in-flight ops),
// in_valid/in_ready/in_data/in_shift_type/in_shift_num/in_imm_form/in_carry (operation),
// out_valid/out_ready/out_data/out_carry (result).
module shift_unit_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_shift_type,
   input  logic [7:0]       in_shift_num,
   input  logic             in_imm_form,
   input  logic             in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry
);

   localparam int         LOG2W = $clog2(WIDTH);
   localparam logic [7:0] W8    = 8'(WIDTH);

   shift_pay_t        pay [STAGES+1];
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] vin;
   logic [STAGES:0]   rdy;

   // ---------------------------------------------------------------
   // Decode: reduce immediate encodings to a register-form amount,
   // compute the carry from the original operand, and turn every
   // out-of-range amount into a zero shift plus an override flag.
   // ---------------------------------------------------------------
   shift_type_t      typ;
   logic [LOG2W-1:0] k;
   logic [LOG2W-1:0] m;
   logic [7:0]       n_eff;
   logic             rrx;

   always_comb begin
      typ        = shift_type_t'(in_shift_type);
      k          = in_shift_num[LOG2W-1:0];
      n_eff      = in_shift_num;
      rrx        = 1'b0;
      pay[0]     = '0;
      pay[0].data = SH_MAX_W'(in_data);
      pay[0].typ  = typ;
      pay[0].carry = in_carry;

      if (in_imm_form) begin
         if (k != '0) begin
            n_eff = 8'(k);
         end else begin
            case (typ)
               SH_LSL:  n_eff = 8'd0;
               SH_LSR,
               SH_ASR:  n_eff = W8;
               default: rrx   = 1'b1;
            endcase
         end
      end

      m = n_eff[LOG2W-1:0];

      if (rrx) begin
         // RRX is a fixed one-bit rotate through carry; resolve it here.
         pay[0].data  = SH_MAX_W'({in_carry, in_data[WIDTH-1:1]});
         pay[0].carry = in_data[0];
      end else if (n_eff != 8'd0) begin
         case (typ)
            SH_LSL: begin
               if (n_eff < W8) begin
                  pay[0].amt   = SH_AMT_W'(m);
                  pay[0].carry = in_data[LOG2W'(W8 - n_eff)];
               end else begin
                  pay[0].force_zero = 1'b1;
                  pay[0].carry      = (n_eff == W8) ? in_data[0] : 1'b0;
               end
            end
            SH_LSR: begin
               if (n_eff < W8) begin
                  pay[0].amt   = SH_AMT_W'(m);
                  pay[0].carry = in_data[LOG2W'(n_eff - 8'd1)];
               end else begin
                  pay[0].force_zero = 1'b1;
                  pay[0].carry      = (n_eff == W8) ? in_data[WIDTH-1] : 1'b0;
               end
            end
            SH_ASR: begin
               if (n_eff < W8) begin
                  pay[0].amt   = SH_AMT_W'(m);
                  pay[0].carry = in_data[LOG2W'(n_eff - 8'd1)];
               end else begin
                  pay[0].force_sign = 1'b1;
                  pay[0].carry      = in_data[WIDTH-1];
               end
            end
            default: begin
               // Multiples of WIDTH rotate back onto x but still set carry.
               if (m == '0) begin
                  pay[0].carry = in_data[WIDTH-1];
               end else begin
                  pay[0].amt   = SH_AMT_W'(m);
                  pay[0].carry = in_data[LOG2W'(m - 1'b1)];
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Ready chain, evaluated from the output back to the input.
   // ---------------------------------------------------------------
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         rdy[i] = !v[i] || rdy[i+1];
      end
   end

   assign in_ready = rdy[0] && !flush;

   // ---------------------------------------------------------------
   // Stage instances.
   // ---------------------------------------------------------------
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign vin[i] = in_valid && in_ready;
      end else begin : g_next
         assign vin[i] = v[i-1];
      end

      shift_layer_stage #(
         .WIDTH     (WIDTH),
         .STAGES    (STAGES),
         .STAGE_IDX (i)
      ) u_stage (
         .clk       (clk),
         .reset_n   (reset_n),
         .flush     (flush),
         .load      (rdy[i]),
         .in_valid  (vin[i]),
         .in_pay    (pay[i]),
         .out_valid (v[i]),
         .out_pay   (pay[i+1])
      );
   end

   assign out_valid = v[STAGES-1];
   assign out_data  = pay[STAGES].data[WIDTH-1:0];
   assign out_carry = pay[STAGES].carry;

   // Bookkeeping fields of the final payload are not needed at the port.
   logic unused_pay;
   assign unused_pay = ^pay[STAGES];

endmodule

// File: tb/tb_shift_unit_pipe.sv
module tb_shift_unit_pipe;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_shift_type;
   logic [7:0]  in_shift_num;
   logic        in_imm_form;
   logic        in_carry;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_carry;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] x;
      logic [1:0]  t;
      logic [7:0]  n;
      logic        imm;
      logic        cin;
      logic [31:0] ey;
      logic        ec;
   } vec_t;

   shift_unit_pipe #(.WIDTH(32), .STAGES(2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_shift_type (in_shift_type),
      .in_shift_num  (in_shift_num),
      .in_imm_form   (in_imm_form),
      .in_carry      (in_carry),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_carry     (out_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Offer one op on an idle pipe and wait (bounded) for its result.
   task automatic run_op(input logic [31:0] x, input logic [1:0] t, input logic [7:0] n,
                         input logic imm, input logic cin,
                         output logic [31:0] y, output logic c, output bit ok);
      @(negedge clk);
      in_data = x; in_shift_type = t; in_shift_num = n;
      in_imm_form = imm; in_carry = cin; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      ok = 1'b0; y = '0; c = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            y = out_data; c = out_carry; ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_shift_type = '0; in_shift_num = '0; in_imm_form = 1'b0; in_carry = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("FAIL reset_out_carry got=%b want=0", out_carry); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      reset_n = 1'b1;
   endtask

   task automatic test_register_form;
      vec_t vs [12];
      logic [31:0] y; logic c; bit ok;
      vs = '{
         '{32'h00000001, 2'd0, 8'd32,  1'b0, 1'b0, 32'h00000000, 1'b1},
         '{32'h00000001, 2'd0, 8'd33,  1'b0, 1'b0, 32'h00000000, 1'b0},
         '{32'h00000001, 2'd0, 8'd0,   1'b0, 1'b1, 32'h00000001, 1'b1},
         '{32'h00000001, 2'd0, 8'd4,   1'b0, 1'b0, 32'h00000010, 1'b0},
         '{32'h80000000, 2'd2, 8'd200, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1},
         '{32'h80000010, 2'd2, 8'd4,   1'b0, 1'b1, 32'hF8000001, 1'b0},
         '{32'h80000000, 2'd1, 8'd31,  1'b0, 1'b0, 32'h00000001, 1'b0},
         '{32'h00000030, 2'd1, 8'd5,   1'b0, 1'b0, 32'h00000001, 1'b1},
         '{32'h80000000, 2'd1, 8'd32,  1'b0, 1'b0, 32'h00000000, 1'b1},
         '{32'h0000000F, 2'd3, 8'd36,  1'b0, 1'b0, 32'hF0000000, 1'b1},
         '{32'h0000000F, 2'd3, 8'd32,  1'b0, 1'b1, 32'h0000000F, 1'b0},
         '{32'h12345678, 2'd3, 8'd8,   1'b0, 1'b1, 32'h78123456, 1'b0}
      };
      foreach (vs[i]) begin
         run_op(vs[i].x, vs[i].t, vs[i].n, vs[i].imm, vs[i].cin, y, c, ok);
         total++;
         if (!ok) begin
            bad++; $display("FAIL reg_timeout[%0d] got=no out_valid want=result", i);
         end else if (y !== vs[i].ey || c !== vs[i].ec) begin
            bad++; $display("FAIL reg_result[%0d] got=%h/c%b want=%h/c%b", i, y, c, vs[i].ey, vs[i].ec);
         end
      end
   endtask

   task automatic test_immediate_form;
      vec_t vs [6];
      logic [31:0] y; logic c; bit ok;
      vs = '{
         '{32'h00000003, 2'd3, 8'd0,   1'b1, 1'b1, 32'h80000001, 1'b1},
         '{32'h80000000, 2'd1, 8'd0,   1'b1, 1'b0, 32'h00000000, 1'b1},
         '{32'h7FFFFFFF, 2'd2, 8'd0,   1'b1, 1'b1, 32'h00000000, 1'b0},
         '{32'h00001234, 2'd0, 8'd0,   1'b1, 1'b1, 32'h00001234, 1'b1},
         '{32'h00000003, 2'd1, 8'h21,  1'b1, 1'b0, 32'h00000001, 1'b1},
         '{32'h00000001, 2'd0, 8'hE3,  1'b1, 1'b1, 32'h00000008, 1'b0}
      };
      foreach (vs[i]) begin
         run_op(vs[i].x, vs[i].t, vs[i].n, vs[i].imm, vs[i].cin, y, c, ok);
         total++;
         if (!ok) begin
            bad++; $display("FAIL imm_timeout[%0d] got=no out_valid want=result", i);
         end else if (y !== vs[i].ey || c !== vs[i].ec) begin
            bad++; $display("FAIL imm_result[%0d] got=%h/c%b want=%h/c%b", i, y, c, vs[i].ey, vs[i].ec);
         end
      end
   endtask

   task automatic test_back_to_back;
      int sent = 0, recv = 0, first_out = -1, first_acc = -1;
      bit saw_ready_low = 1'b0, holding = 1'b0;
      logic [31:0] held = '0;
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
         @(negedge clk);
         in_valid = (sent < 4);
         in_data = 32'(sent + 1); in_shift_type = 2'd0; in_shift_num = 8'd1;
         in_imm_form = 1'b0; in_carry = 1'b0;
         out_ready = !(first_out >= 0 && cyc > first_out && cyc <= first_out + 3);
         #1;
         if (in_valid && !in_ready) saw_ready_low = 1'b1;
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end
         if (out_valid) begin
            if (first_out < 0) begin
               first_out = cyc;
               total++;
               if (cyc - first_acc != 2) begin
                  bad++; $display("FAIL b2b_latency got=%0d want=2", cyc - first_acc);
               end
            end
            total++;
            if (out_data !== 32'((recv + 1) * 2)) begin
               bad++; $display("FAIL b2b_order[%0d] got=%h want=%h", recv, out_data, 32'((recv + 1) * 2));
            end
            if (holding) begin
               total++;
               if (out_data !== held) begin
                  bad++; $display("FAIL b2b_stable got=%h want=%h", out_data, held);
               end
            end
            if (out_ready) begin
               recv++; holding = 1'b0;
            end else begin
               holding = 1'b1; held = out_data;
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (recv != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", recv); end
      total++; if (!saw_ready_low) begin bad++; $display("FAIL b2b_in_ready_drop got=never0 want=0 seen"); end
   endtask

   task automatic test_flush;
      logic [31:0] y; logic c; bit ok;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd5; in_shift_type = 2'd0;
      in_shift_num = 8'd1; in_imm_form = 1'b0; in_carry = 1'b0;
      @(negedge clk);
      in_data = 32'd6;
      @(negedge clk);
      in_data = 32'd9; flush = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid[%0d] got=%b want=0", i, out_valid); end
         @(negedge clk);
      end
      run_op(32'd7, 2'd0, 8'd2, 1'b0, 1'b0, y, c, ok);
      total++;
      if (!ok || y !== 32'd28) begin bad++; $display("FAIL flush_recover got=%h ok=%b want=0000001c", y, ok); end
   endtask

   task automatic test_async_reset;
      logic [31:0] y; logic c; bit ok;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h30; in_shift_type = 2'd1;
      in_shift_num = 8'd5; in_imm_form = 1'b0; in_carry = 1'b0;
      @(negedge clk);
      in_data = 32'h40;
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h1 || out_carry !== 1'b1) begin
         bad++; $display("FAIL arst_pre got=%b/%h/c%b want=1/00000001/c1", out_valid, out_data, out_carry);
      end
      #2 reset_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL arst_out_data got=%h want=0", out_data); end
      total++; if (out_carry !== 1'b0) begin bad++; $display("FAIL arst_out_carry got=%b want=0", out_carry); end
      @(negedge clk);
      reset_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_residue got=%b want=0", out_valid); end
      run_op(32'h00000001, 2'd0, 8'd3, 1'b0, 1'b0, y, c, ok);
      total++;
      if (!ok || y !== 32'h8) begin bad++; $display("FAIL arst_recover got=%h ok=%b want=00000008", y, ok); end
   endtask

   initial begin
      test_reset();
      test_register_form();
      test_immediate_form();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
